// File: rtl/sst_pkg.sv
// Shared definitions for the save-state sequencer.
//   sst_seq_st_t : sequencer state encoding.
//   sst_drv_t    : registered bundle driving the mapper's sst port (act, we_reg, addr, dato).
//   SST_IDX_ADDR : sst address at which the mapper returns its map index.
//   CNT_W        : width of the register address counter.
package sst_pkg;

   localparam logic [7:0] SST_IDX_ADDR = 8'd127;
   localparam int unsigned CNT_W       = 7;

   typedef enum logic [2:0] {
      StIdle,
      StSAddr,
      StSHold,
      StRChk,
      StRWait,
      StRWr,
      StDone,
      StErr
   } sst_seq_st_t;

   typedef struct packed {
      logic       act;
      logic       we_reg;
      logic [7:0] addr;
      logic [7:0] dato;
   } sst_drv_t;

   // Register addresses live in the lower half of the 8-bit sst address space.
   function automatic logic [7:0] cnt_to_addr(input logic [CNT_W-1:0] cnt);
      return {1'b0, cnt};
   endfunction

endpackage

// File: rtl/sst_seq_cnt.sv
// Register address counter for the save-state sequencer.
//   clk_i  : clock, state changes on the falling edge (CPU M2 timing).
//   rst_ni : asynchronous active-low reset, counter to 0.
//   clr_i  : synchronous clear to 0 (has priority over inc_i).
//   inc_i  : advance by one; saturates at NREG-1 so the count never wraps.
//   cnt_o  : current register address.
//   last_o : high when cnt_o addresses the final register (NREG-1).
module sst_seq_cnt
   import sst_pkg::*;
#(
   parameter int unsigned NREG = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             last_o
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NREG - 1);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LastCnt)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == LastCnt);

endmodule

// File: rtl/sst_seq.sv
// Save-state sequencer between the save-state host and one mapper's sst port.
// Save streams registers 0..NREG-1 out over a valid/ready channel; restore first checks
// the mapper's map index at IDX_ADDR and then writes NREG streamed bytes back.
//   m2, rst_n              : clock (falling edge active) and async active-low reset.
//   start, dir, abort      : operation control; dir 0 = save, 1 = restore.
//   exp_idx                : map index a restore image expects.
//   busy, done, err        : status; done/err are one-cycle pulses.
//   out_valid/ready/addr/data : save byte stream to the host.
//   in_valid/ready/data    : restore byte stream from the host.
//   sst_act, sst_we_reg, sst_addr, sst_dato, sst_di : mapper sst port.
module sst_seq
   import sst_pkg::*;
#(
   parameter int unsigned NREG     = 16,
   parameter logic [7:0]  IDX_ADDR = SST_IDX_ADDR
) (
   input  logic       m2,
   input  logic       rst_n,
   input  logic       start,
   input  logic       dir,
   input  logic       abort,
   input  logic [7:0] exp_idx,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_addr,
   output logic [7:0] out_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       sst_act,
   output logic       sst_we_reg,
   output logic [7:0] sst_addr,
   output logic [7:0] sst_dato,
   input  logic [7:0] sst_di
);

   sst_seq_st_t state_d, state_q;
   sst_drv_t    drv_d, drv_q;
   logic        busy_d, busy_q;
   logic        done_d, done_q;
   logic        err_d, err_q;
   logic        out_valid_d, out_valid_q;
   logic [7:0]  out_addr_d, out_addr_q;
   logic [7:0]  out_data_d, out_data_q;
   logic        in_ready_d, in_ready_q;

   logic             cnt_clr;
   logic             cnt_inc;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;

   sst_seq_cnt #(
      .NREG (NREG)
   ) u_cnt (
      .clk_i  (m2),
      .rst_ni (rst_n),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .cnt_o  (cnt),
      .last_o (cnt_last)
   );

   always_comb begin
      state_d     = state_q;
      drv_d       = drv_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      in_ready_d  = in_ready_q;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;

      if (abort) begin
         // Abort beats everything, including a start in idle. A write already on the bus in
         // StRWr is still seen by the mapper on this edge.
         state_d     = StIdle;
         drv_d       = '0;
         busy_d      = 1'b0;
         out_valid_d = 1'b0;
         out_addr_d  = '0;
         out_data_d  = '0;
         in_ready_d  = 1'b0;
         cnt_clr     = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  busy_d      = 1'b1;
                  drv_d.act   = 1'b1;
                  drv_d.we_reg = 1'b0;
                  drv_d.dato  = '0;
                  cnt_clr     = 1'b1;
                  if (dir) begin
                     state_d    = StRChk;
                     drv_d.addr = IDX_ADDR;
                  end else begin
                     state_d    = StSAddr;
                     drv_d.addr = 8'h00;
                  end
               end
            end

            // Address was registered on the previous edge; sst_di is valid now.
            StSAddr: begin
               out_data_d  = sst_di;
               out_addr_d  = cnt_to_addr(cnt);
               out_valid_d = 1'b1;
               state_d     = StSHold;
            end

            StSHold: begin
               if (out_valid_q && out_ready) begin
                  out_valid_d = 1'b0;
                  if (cnt_last) begin
                     state_d = StDone;
                     done_d  = 1'b1;
                     drv_d   = '0;
                  end else begin
                     cnt_inc    = 1'b1;
                     drv_d.addr = cnt_to_addr(cnt) + 8'd1;
                     state_d    = StSAddr;
                  end
               end
            end

            StRChk: begin
               if (sst_di == exp_idx) begin
                  state_d    = StRWait;
                  in_ready_d = 1'b1;
                  cnt_clr    = 1'b1;
               end else begin
                  state_d = StErr;
                  err_d   = 1'b1;
                  drv_d   = '0;
               end
            end

            StRWait: begin
               if (in_valid && in_ready_q) begin
                  in_ready_d   = 1'b0;
                  drv_d.we_reg = 1'b1;
                  drv_d.addr   = cnt_to_addr(cnt);
                  drv_d.dato   = in_data;
                  state_d      = StRWr;
               end
            end

            // we_reg is high for exactly this one cycle.
            StRWr: begin
               drv_d.we_reg = 1'b0;
               if (cnt_last) begin
                  state_d = StDone;
                  done_d  = 1'b1;
                  drv_d   = '0;
               end else begin
                  cnt_inc    = 1'b1;
                  in_ready_d = 1'b1;
                  state_d    = StRWait;
               end
            end

            StDone, StErr: begin
               state_d    = StIdle;
               busy_d     = 1'b0;
               out_addr_d = '0;
               out_data_d = '0;
            end

            default: begin
               state_d = StIdle;
               drv_d   = '0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(negedge m2 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         drv_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         drv_q       <= drv_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign out_valid  = out_valid_q;
   assign out_addr   = out_addr_q;
   assign out_data   = out_data_q;
   assign in_ready   = in_ready_q;
   assign sst_act    = drv_q.act;
   assign sst_we_reg = drv_q.we_reg;
   assign sst_addr   = drv_q.addr;
   assign sst_dato   = drv_q.dato;

endmodule

// File: tb/tb_sst_seq.sv
// Directed bench for sst_seq with a small mapper register-file model on the sst port.
module tb_sst_seq;

   localparam int unsigned NREG = 16;

   logic       m2 = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       dir = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] exp_idx = 8'd0;
   logic       busy, done, err;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_addr, out_data;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'd0;
   logic       sst_act, sst_we_reg;
   logic [7:0] sst_addr, sst_dato, sst_di;

   int tests = 0;
   int fails = 0;

   // Mapper model: registers 0..15 plus the map index at 127; writes land on we_reg cycles.
   logic [7:0] mreg [NREG];
   logic [7:0] map_idx = 8'd0;
   logic       preload_en = 1'b0;
   logic [7:0] preload_base = 8'd0;
   int         wr_cnt = 0;
   int         we_viol = 0;
   int         we_dbl = 0;
   logic       prev_we = 1'b0;
   logic [7:0] wr_addr_log [64];
   logic [7:0] wr_dato_log [64];

   assign sst_di = (sst_addr == 8'd127) ? map_idx : mreg[sst_addr[3:0]];

   always @(posedge m2) begin
      if (preload_en) begin
         for (int i = 0; i < NREG; i++) mreg[i] <= preload_base + 8'(i);
      end else if (sst_we_reg) begin
         mreg[sst_addr[3:0]] <= sst_dato;
      end
      if (sst_we_reg) begin
         if (!sst_act) we_viol <= we_viol + 1;
         if (prev_we) we_dbl <= we_dbl + 1;
         if (wr_cnt < 64) begin
            wr_addr_log[wr_cnt] <= sst_addr;
            wr_dato_log[wr_cnt] <= sst_dato;
         end
         wr_cnt <= wr_cnt + 1;
      end
      prev_we <= sst_we_reg;
   end

   sst_seq #(
      .NREG     (NREG),
      .IDX_ADDR (8'd127)
   ) dut (
      .m2         (m2),
      .rst_n      (rst_n),
      .start      (start),
      .dir        (dir),
      .abort      (abort),
      .exp_idx    (exp_idx),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .sst_act    (sst_act),
      .sst_we_reg (sst_we_reg),
      .sst_addr   (sst_addr),
      .sst_dato   (sst_dato),
      .sst_di     (sst_di)
   );

   always #5 m2 = ~m2;

   // DUT updates on the falling edge; the bench samples and drives just after the rising edge.
   task automatic tick();
      @(posedge m2);
      #1;
   endtask

   task automatic preload(input logic [7:0] base);
      preload_base = base;
      preload_en   = 1'b1;
      tick();
      preload_en   = 1'b0;
   endtask

   task automatic pulse_start(input logic d);
      tick();
      start = 1'b1;
      dir   = d;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({busy, done, err, out_valid, in_ready, sst_act, sst_we_reg} !== 7'd0) begin
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {busy, done, err, out_valid, in_ready, sst_act, sst_we_reg});
         fails++;
      end
      tests++;
      if ({sst_addr, sst_dato, out_addr, out_data} !== 32'd0) begin
         $display("FAIL reset_data: got %h want 00000000", {sst_addr, sst_dato, out_addr, out_data});
         fails++;
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_save();
      int nb = 0, ndone = 0, act_drop = 0, base;
      bit fin = 0;
      logic [7:0] exp_b;
      preload(8'h10);
      base      = wr_cnt;
      out_ready = 1'b1;
      pulse_start(1'b0);
      for (int c = 0; c < 200; c++) begin
         tick();
         if (done) ndone++;
         if (!busy) begin
            fin = 1;
            break;
         end
         if (!done && !sst_act) act_drop++;
         if (out_valid && out_ready) begin
            exp_b = 8'h10 + 8'(nb);
            tests++;
            if (out_addr !== 8'(nb) || out_data !== exp_b) begin
               $display("FAIL save_byte[%0d]: got addr %0d data %h want addr %0d data %h",
                        nb, out_addr, out_data, nb, exp_b);
               fails++;
            end
            nb++;
         end
      end
      tests++;
      if (!fin) begin
         $display("FAIL save_timeout: got busy %b want 0", busy);
         fails++;
      end
      tests++;
      if (nb != 16) begin
         $display("FAIL save_count: got %0d want 16", nb);
         fails++;
      end
      tests++;
      if (ndone != 1) begin
         $display("FAIL save_done: got %0d want 1", ndone);
         fails++;
      end
      tests++;
      if (wr_cnt - base != 0) begin
         $display("FAIL save_we: got %0d writes want 0", wr_cnt - base);
         fails++;
      end
      tests++;
      if (act_drop != 0) begin
         $display("FAIL save_act: got %0d drops want 0", act_drop);
         fails++;
      end
   endtask

   task automatic test_save_stall();
      int nb = 0, ndone = 0, stall = 0;
      bit fin = 0;
      logic [7:0] exp_b;
      preload(8'h10);
      out_ready = 1'b1;
      pulse_start(1'b0);
      for (int c = 0; c < 200; c++) begin
         tick();
         start = 1'b0;
         if (done) ndone++;
         if (!busy) begin
            fin = 1;
            break;
         end
         if (out_valid && out_addr == 8'd3 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
            tests++;
            if (out_data !== 8'h13 || !sst_act || sst_addr !== 8'd3) begin
               $display("FAIL stall_hold[%0d]: got data %h act %b sst_addr %0d want 13 1 3",
                        stall, out_data, sst_act, sst_addr);
               fails++;
            end
            // A start while busy must be ignored.
            if (stall == 2) begin
               start = 1'b1;
               dir   = 1'b1;
            end
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) begin
            exp_b = 8'h10 + 8'(nb);
            tests++;
            if (out_addr !== 8'(nb) || out_data !== exp_b) begin
               $display("FAIL stall_byte[%0d]: got addr %0d data %h want addr %0d data %h",
                        nb, out_addr, out_data, nb, exp_b);
               fails++;
            end
            nb++;
         end
      end
      start = 1'b0;
      tests++;
      if (!fin || nb != 16 || ndone != 1 || stall != 5) begin
         $display("FAIL stall_summary: got fin %0d bytes %0d done %0d stalls %0d want 1 16 1 5",
                  fin, nb, ndone, stall);
         fails++;
      end
   endtask

   task automatic test_restore();
      int k = 0, ndone = 0, nerr = 0, base;
      bit fin = 0;
      logic [7:0] exp_b;
      preload(8'h00);
      base    = wr_cnt;
      map_idx = 8'd65;
      exp_idx = 8'd65;
      pulse_start(1'b1);
      for (int c = 0; c < 200; c++) begin
         tick();
         if (done) ndone++;
         if (err) nerr++;
         if (!busy) begin
            fin = 1;
            break;
         end
         in_valid = in_ready;
         in_data  = 8'hA0 + 8'(k);
         if (in_ready) k++;
      end
      in_valid = 1'b0;
      tests++;
      if (!fin || ndone != 1 || nerr != 0) begin
         $display("FAIL restore_status: got fin %0d done %0d err %0d want 1 1 0", fin, ndone, nerr);
         fails++;
      end
      tests++;
      if (wr_cnt - base != 16) begin
         $display("FAIL restore_writes: got %0d want 16", wr_cnt - base);
         fails++;
      end
      for (int i = 0; i < 16; i++) begin
         exp_b = 8'hA0 + 8'(i);
         tests++;
         if (wr_addr_log[base+i] !== 8'(i) || wr_dato_log[base+i] !== exp_b || mreg[i] !== exp_b)
         begin
            $display("FAIL restore_wr[%0d]: got addr %0d dato %h reg %h want addr %0d data %h",
                     i, wr_addr_log[base+i], wr_dato_log[base+i], mreg[i], i, exp_b);
            fails++;
         end
      end
      tests++;
      if (we_dbl != 0 || we_viol != 0) begin
         $display("FAIL restore_we_shape: got dbl %0d noact %0d want 0 0", we_dbl, we_viol);
         fails++;
      end
   endtask

   task automatic test_idx_mismatch();
      int ndone = 0, nerr = 0, base;
      bit fin = 0;
      base    = wr_cnt;
      map_idx = 8'd4;
      exp_idx = 8'd65;
      pulse_start(1'b1);
      for (int c = 0; c < 10; c++) begin
         tick();
         if (done) ndone++;
         if (err) begin
            nerr++;
            tick();
            tests++;
            if (busy !== 1'b0 || err !== 1'b0 || sst_act !== 1'b0) begin
               $display("FAIL err_release: got busy %b err %b act %b want 0 0 0", busy, err, sst_act);
               fails++;
            end
            fin = 1;
            break;
         end
      end
      tests++;
      if (!fin || nerr != 1 || ndone != 0) begin
         $display("FAIL err_pulse: got fin %0d err %0d done %0d want 1 1 0", fin, nerr, ndone);
         fails++;
      end
      tests++;
      if (wr_cnt - base != 0) begin
         $display("FAIL err_writes: got %0d want 0", wr_cnt - base);
         fails++;
      end
   endtask

   task automatic test_abort_restore();
      int k = 0, nflag = 0, base;
      bit aborted = 0;
      preload(8'h50);
      base    = wr_cnt;
      map_idx = 8'd65;
      exp_idx = 8'd65;
      pulse_start(1'b1);
      for (int c = 0; c < 200; c++) begin
         tick();
         if (done || err) nflag++;
         if (k == 8 && sst_we_reg) begin
            tests++;
            if (sst_addr !== 8'd7) begin
               $display("FAIL abort_wr_addr: got %0d want 7", sst_addr);
               fails++;
            end
            abort    = 1'b1;
            in_valid = 1'b0;
            tick();
            abort = 1'b0;
            tests++;
            if ({busy, sst_act, sst_we_reg, in_ready, done, err} !== 6'd0) begin
               $display("FAIL abort_idle: got %b want 000000",
                        {busy, sst_act, sst_we_reg, in_ready, done, err});
               fails++;
            end
            aborted = 1;
            break;
         end
         in_valid = in_ready;
         in_data  = 8'hA0 + 8'(k);
         if (in_ready) k++;
      end
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (done || err || busy) nflag++;
      end
      tests++;
      if (!aborted || nflag != 0) begin
         $display("FAIL abort_flags: got aborted %0d flags %0d want 1 0", aborted, nflag);
         fails++;
      end
      tests++;
      if (wr_cnt - base != 8 || mreg[7] !== 8'hA7 || mreg[8] !== 8'h58) begin
         $display("FAIL abort_writes: got %0d reg7 %h reg8 %h want 8 a7 58",
                  wr_cnt - base, mreg[7], mreg[8]);
         fails++;
      end
   endtask

   task automatic test_abort_start();
      tick();
      start = 1'b1;
      abort = 1'b1;
      dir   = 1'b0;
      tick();
      start = 1'b0;
      abort = 1'b0;
      tests++;
      if (busy !== 1'b0 || sst_act !== 1'b0) begin
         $display("FAIL abort_start: got busy %b act %b want 0 0", busy, sst_act);
         fails++;
      end
      tick();
      tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         $display("FAIL abort_start_later: got busy %b valid %b want 0 0", busy, out_valid);
         fails++;
      end
   endtask

   task automatic test_reset_mid_save();
      int ndone = 0;
      bit fin = 0;
      preload(8'h10);
      out_ready = 1'b1;
      pulse_start(1'b0);
      for (int c = 0; c < 6; c++) tick();
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if (sst_act !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         $display("FAIL rst_async: got act %b busy %b valid %b want 0 0 0", sst_act, busy, out_valid);
         fails++;
      end
      tick();
      rst_n = 1'b1;
      pulse_start(1'b0);
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_addr !== 8'd0 || out_data !== 8'h10) begin
         $display("FAIL rst_first_byte: got valid %b addr %0d data %h want 1 0 10",
                  out_valid, out_addr, out_data);
         fails++;
      end
      for (int c = 0; c < 200; c++) begin
         tick();
         if (done) ndone++;
         if (!busy) begin
            fin = 1;
            break;
         end
      end
      tests++;
      if (!fin || ndone != 1) begin
         $display("FAIL rst_resume: got fin %0d done %0d want 1 1", fin, ndone);
         fails++;
      end
   endtask

   initial begin
      test_reset();
      test_save();
      test_save_stall();
      test_restore();
      test_idx_mismatch();
      test_abort_restore();
      test_abort_start();
      test_reset_mid_save();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sst_seq.md
Name: sst_seq

Overview:
- Save-state sequencer for one mapper's sst register file (chr banks, prg banks, IRQ counter/reload, mirroring/IRQ flags, map index at address 127).
- Sits between the save-state host (menu/DMA side) and the mapper's sst port.
- Save: walks addresses 0..NREG-1, streams each byte out with a valid/ready handshake.
- Restore: checks the map index at address 127, then writes NREG streamed bytes back through sst.we_reg while holding sst.act.

Parameters:
- NREG, 16, number of mapper state registers, addresses 0..NREG-1; range 1..127.
- IDX_ADDR, 127, sst address returning cfg.map_idx.

Ports:
- m2  input  1  clock; CPU M2, all state updates on its negative edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins an operation when idle.
- dir  input  1  sampled with start; 0 = save, 1 = restore.
- abort  input  1  forces return to IDLE from any state.
- exp_idx  input  8  expected map index for restore check.
- busy  output  1  high from accepted start until DONE/ERR is left.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  one-cycle pulse on map-index mismatch.
- out_valid  output  1  save byte available.
- out_ready  input  1  host accepts save byte.
- out_addr  output  8  sst address of out_data.
- out_data  output  8  saved register byte.
- in_valid  input  1  restore byte available.
- in_ready  output  1  sequencer accepts restore byte.
- in_data  input  8  restore register byte.
- sst_act  output  1  drives sst.act.
- sst_we_reg  output  1  drives sst.we_reg.
- sst_addr  output  8  drives sst.addr.
- sst_dato  output  8  drives sst.dato.
- sst_di  input  8  mapper readback (mao.sst_di).

Behaviour:
- Reset: state IDLE. All outputs 0. Address counter 0.
- States: IDLE, S_ADDR, S_HOLD, R_CHK, R_WAIT, R_WR, DONE, ERR.
- IDLE:
  - start=1 with dir=0 -> S_ADDR, counter=0.
  - start=1 with dir=1 -> R_CHK with sst_addr=IDX_ADDR.
  - start while busy is ignored.
- Save path:
  - S_ADDR: sst_act=1, sst_addr=counter. Next edge: latch sst_di into out_data, out_addr=counter, go to S_HOLD. Readback latency is 1 cycle after the address is registered.
  - S_HOLD: out_valid=1, held stable until out_ready.
  - On out_valid & out_ready: if counter==NREG-1 -> DONE, else counter+1 -> S_ADDR.
- Restore path:
  - R_CHK: sst_act=1, sst_addr=IDX_ADDR. Next edge compares sst_di with exp_idx: mismatch -> ERR with no writes issued; match -> R_WAIT, counter=0.
  - R_WAIT: sst_act=1, in_ready=1, sst_we_reg=0.
  - On in_valid & in_ready: sst_addr=counter, sst_dato=in_data, go to R_WR.
  - R_WR: sst_we_reg=1 for exactly one cycle, in_ready=0. Then: counter==NREG-1 -> DONE, else counter+1 -> R_WAIT.
- sst_act:
  - High in every state except IDLE, DONE, ERR.
  - Never deasserted between bytes of one operation.
  - sst_we_reg is only ever high while sst_act is high.
- DONE pulses done=1; ERR pulses err=1. Both last one cycle, then return to IDLE with busy=0.
- Counter is 7-bit and never wraps; the terminal compare is NREG-1.
- Host stalls (out_ready=0, in_valid=0) hold state indefinitely with sst_act=1. No timeout.
- Abort: next edge -> IDLE, all outputs 0, no done/err pulse. If abort occurs during R_WR, that write still completes in the current cycle.
- Async reset mid-operation: immediate IDLE, sst_act and sst_we_reg drop asynchronously.
- Simultaneous abort and start in IDLE: abort wins, start is ignored.

Decomposition:
- Shared package sst_pkg:
  - state enum sst_seq_st_t.
  - constant SST_IDX_ADDR=8'd127.
  - struct SstDrv {act, we_reg, addr[7:0], dato[7:0]}, used to assemble SSTBus.
- One sub-module is natural: sst_seq_cnt, the address counter with terminal compare and clear/increment.

Test Plan:
- Save, NREG=16, mapper regs preloaded 0x10+i, out_ready always 1 -> 16 bytes out with out_addr 0..15 and data 0x10..0x1F; done pulses once; sst_we_reg never high.
- Save with out_ready low 5 cycles on byte 3 -> out_data/out_addr held at 3/0x13, sst_act stays 1, then sequence resumes; total 16 bytes.
- Restore, exp_idx=65, sst_di@127=65, in_data=0xA0+i -> 16 single-cycle we_reg pulses at addr 0..15 with dato 0xA0..0xAF; mapper readback matches; done pulse.
- Restore, exp_idx=65, sst_di@127=4 -> err pulse, zero we_reg pulses, busy drops after 1 cycle.
- Abort asserted at byte 7 of restore -> IDLE next edge; exactly 7 or 8 writes issued (8 if in R_WR); no done/err.
- rst_n low mid-save -> sst_act=0 immediately; after release start works and returns byte 0 first.
